// File: rtl/crack_pkg.sv
// crack_pkg: shared FSM state type, plaintext length address and lane slicing helper
package crack_pkg;
   typedef enum logic [2:0] {S_IDLE, S_START, S_SEARCH, S_ABORT, S_LEN, S_COPY} state_t;
   localparam logic [7:0] PT_LEN_ADDR = 8'd0;
   localparam int SLICE_MAX = 256;
   function automatic logic [31:0] lane_slice(input logic [SLICE_MAX-1:0] p, input int idx, input int w = 8);
      logic [31:0] m;
      m = (32'd1 << w) - 32'd1;
      return 32'(p >> (idx * w)) & m;
   endfunction
endpackage

// File: rtl/multi_crack_ctrl_if.sv
// multi_crack_ctrl_if: task-controller, lane and plaintext RAM signals of the crack coordinator
interface multi_crack_ctrl_if #(parameter int N_LANES = 2, parameter int KEY_W = 24);
   logic                     en;
   logic                     rdy;
   logic [KEY_W-1:0]         key;
   logic                     key_valid;
   logic [N_LANES-1:0]       lane_start;
   logic [N_LANES-1:0]       lane_abort;
   logic [N_LANES-1:0]       lane_done;
   logic [N_LANES-1:0]       lane_found;
   logic [N_LANES*KEY_W-1:0] lane_key;
   logic [7:0]               lane_pt_addr;
   logic [N_LANES*8-1:0]     lane_pt_rddata;
   logic [7:0]               pt_addr;
   logic [7:0]               pt_wrdata;
   logic                     pt_wren;
   logic [10:0]              str_len;
   modport master (
      output en, lane_done, lane_found, lane_key, lane_pt_rddata,
      input  rdy, key, key_valid, lane_start, lane_abort, lane_pt_addr, pt_addr, pt_wrdata, pt_wren, str_len
   );
   modport slave (
      input  en, lane_done, lane_found, lane_key, lane_pt_rddata,
      output rdy, key, key_valid, lane_start, lane_abort, lane_pt_addr, pt_addr, pt_wrdata, pt_wren, str_len
   );
endinterface

// File: rtl/multi_crack_ctrl_pt_copier.sv
// pt_copier: reads the length byte then streams bytes 1..L from the winning lane RAM into the output RAM
module pt_copier
   import crack_pkg::*;
#(
   parameter int N_LANES = 2,
   parameter int LW      = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic [LW-1:0]        i_sel,
   input  logic [N_LANES*8-1:0] i_rddata,
   output logic [7:0]           o_rdaddr,
   output logic [7:0]           o_addr,
   output logic [7:0]           o_wrdata,
   output logic                 o_wren,
   output logic                 o_len_vld,
   output logic [7:0]           o_len,
   output logic                 o_done
);
   logic                 r_wait;
   logic                 r_len_wr;
   logic                 r_copy;
   logic [8:0]           r_wa;
   logic [7:0]           r_len;
   logic [SLICE_MAX-1:0] w_rd_ext;
   logic [7:0]           w_byte;

   assign w_rd_ext = SLICE_MAX'(i_rddata);
   assign w_byte   = 8'(lane_slice(w_rd_ext, int'(i_sel)));

   // phase pipeline: address 0 read wait, length write, then one byte per cycle; 9-bit write address so k=255 ends cleanly
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wait   <= 1'b0;
         r_len_wr <= 1'b0;
         r_copy   <= 1'b0;
         r_wa     <= '0;
         r_len    <= '0;
      end else begin
         r_wait   <= i_start;
         r_len_wr <= r_wait;
         if (r_len_wr) begin
            r_len  <= w_byte;
            r_copy <= w_byte != 8'd0;
            r_wa   <= 9'd1;
         end else if (r_copy) begin
            r_copy <= r_wa != {1'b0, r_len};
            r_wa   <= r_wa + 9'd1;
         end
      end
   end

   // read address runs one ahead of the write address to cover the 1-cycle RAM latency
   always_comb begin
      o_rdaddr  = r_len_wr ? 8'd1 : r_copy ? r_wa[7:0] + 8'd1 : PT_LEN_ADDR;
      o_addr    = r_copy ? r_wa[7:0] : PT_LEN_ADDR;
      o_wrdata  = w_byte;
      o_wren    = r_len_wr | r_copy;
      o_len_vld = r_len_wr;
      o_len     = w_byte;
      o_done    = r_copy && r_wa == {1'b0, r_len};
   end
endmodule

// File: rtl/multi_crack_ctrl.sv
// multi_crack_ctrl: N-lane ARC4 key-search coordinator; optional cycle counter under CRACK_CYCLE_CNT_EN
module multi_crack_ctrl
   import crack_pkg::*;
#(
   parameter int N_LANES = 2,
   parameter int KEY_W   = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   multi_crack_ctrl_if.slave bus
`ifdef CRACK_CYCLE_CNT_EN
   ,
   output logic [31:0]      cycles
`endif
);
   localparam int LW = N_LANES > 1 ? $clog2(N_LANES) : 1;

   state_t               r_state;
   state_t               w_next;
   logic [KEY_W-1:0]     r_key;
   logic                 r_key_valid;
   logic [LW-1:0]        r_win;
   logic [LW-1:0]        w_idx;
   logic [10:0]          r_str_len;
   logic [N_LANES-1:0]   w_f;
   logic [SLICE_MAX-1:0] w_key_ext;
   logic [7:0]           w_rdaddr;
   logic [7:0]           w_addr;
   logic [7:0]           w_wrdata;
   logic [7:0]           w_len;
   logic                 w_wren;
   logic                 w_len_vld;
   logic                 w_done;

   assign w_f       = bus.lane_done & bus.lane_found;
   assign w_key_ext = SLICE_MAX'(bus.lane_key);

   // lowest-index finder wins
   always_comb begin
      w_idx = '0;
      for (int i = N_LANES - 1; i >= 0; i--)
         if (w_f[i]) w_idx = LW'(i);
   end

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next state and outputs; every output is forced to its reset value while rst_n is low
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = bus.en ? S_START : S_IDLE;
         S_START:  w_next = S_SEARCH;
         S_SEARCH: w_next = |w_f ? S_ABORT : &bus.lane_done ? S_IDLE : S_SEARCH;
         S_ABORT:  w_next = S_LEN;
         S_LEN:    w_next = !w_len_vld ? S_LEN : w_len == 8'd0 ? S_IDLE : S_COPY;
         S_COPY:   w_next = w_done ? S_IDLE : S_COPY;
         default:  w_next = S_IDLE;
      endcase
      bus.rdy          = rst_n & (r_state == S_IDLE);
      bus.lane_start   = {N_LANES{rst_n & (r_state == S_START)}};
      bus.lane_abort   = (rst_n & (r_state == S_ABORT)) ? ~(N_LANES'(1) << r_win) : '0;
      bus.key          = rst_n ? r_key : '0;
      bus.key_valid    = rst_n & r_key_valid;
      bus.str_len      = rst_n ? r_str_len : '0;
      bus.lane_pt_addr = rst_n ? w_rdaddr : '0;
      bus.pt_addr      = rst_n ? w_addr : '0;
      bus.pt_wrdata    = rst_n ? w_wrdata : '0;
      bus.pt_wren      = rst_n & w_wren;
   end

   // result registers: cleared on accept, key latched on a win, length latched from the copier
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_key       <= '0;
         r_key_valid <= 1'b0;
         r_win       <= '0;
         r_str_len   <= '0;
      end else begin
         if (r_state == S_IDLE && bus.en) begin
            r_key_valid <= 1'b0;
            r_str_len   <= '0;
         end
         if (r_state == S_SEARCH && |w_f) begin
            r_win       <= w_idx;
            r_key       <= KEY_W'(lane_slice(w_key_ext, int'(w_idx), KEY_W));
            r_key_valid <= 1'b1;
         end
         if (r_state == S_SEARCH && ~|w_f && &bus.lane_done) r_key_valid <= 1'b0;
         if (r_state == S_LEN && w_len_vld) r_str_len <= 11'(w_len);
      end
   end

   pt_copier #(.N_LANES(N_LANES), .LW(LW)) u_copier (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_start   (r_state == S_ABORT),
      .i_sel     (r_win),
      .i_rddata  (bus.lane_pt_rddata),
      .o_rdaddr  (w_rdaddr),
      .o_addr    (w_addr),
      .o_wrdata  (w_wrdata),
      .o_wren    (w_wren),
      .o_len_vld (w_len_vld),
      .o_len     (w_len),
      .o_done    (w_done)
   );

`ifdef CRACK_CYCLE_CNT_EN
   logic [31:0] r_cycles;

   // busy-cycle counter: cleared on accept, counts until back in IDLE, saturates
   always_ff @(posedge clk) begin
      if (!rst_n)                                 r_cycles <= '0;
      else if (r_state == S_IDLE && bus.en)       r_cycles <= '0;
      else if (r_state != S_IDLE && ~&r_cycles)   r_cycles <= r_cycles + 32'd1;
   end

   assign cycles = r_cycles;
`endif
endmodule
